// File: rtl/mem_copy_if.sv
// rtl/mem_copy_if.sv - control and dual-port RAM bus bundle for mem_copy_engine
// slave = the engine, master = host plus RAM; fill ports exist only with MEM_COPY_FILL_EN.
interface mem_copy_if #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 16
);
    logic              start;
    logic              abort;
    logic [ADDR_W-1:0] src_base;
    logic [ADDR_W-1:0] dst_base;
    logic [ADDR_W:0]   len;
    logic              busy;
    logic              done;
    logic              aborted;
    logic [ADDR_W:0]   words_done;
    logic              ena;
    logic              wea;
    logic [ADDR_W-1:0] addra;
    logic [DATA_W-1:0] doa;
    logic              enb;
    logic              web;
    logic [ADDR_W-1:0] addrb;
    logic [DATA_W-1:0] dib;
`ifdef MEM_COPY_FILL_EN
    logic              fill_mode;
    logic [DATA_W-1:0] fill_data;
`endif

    modport master (
        output start, abort, src_base, dst_base, len, doa,
`ifdef MEM_COPY_FILL_EN
        output fill_mode, fill_data,
`endif
        input  busy, done, aborted, words_done,
        input  ena, wea, addra, enb, web, addrb, dib
    );

    modport slave (
        input  start, abort, src_base, dst_base, len, doa,
`ifdef MEM_COPY_FILL_EN
        input  fill_mode, fill_data,
`endif
        output busy, done, aborted, words_done,
        output ena, wea, addra, enb, web, addrb, dib
    );
endinterface

// File: rtl/mem_copy_engine.sv
// rtl/mem_copy_engine.sv - block copy engine driving both ports of a sync-read dual-port RAM
// Optional constant-fill mode is enabled by defining MEM_COPY_FILL_EN.
module mem_copy_engine #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 16
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    mem_copy_if.slave    bus
);
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    localparam logic [ADDR_W:0]   CNT_ONE  = 1;
    localparam logic [ADDR_W-1:0] ADDR_ONE = 1;

    state_t            r_state;
    logic              r_busy, r_done, r_aborted;
    logic              r_ena, r_enb, r_web;
    logic [ADDR_W-1:0] r_addra, r_addrb, r_wr_addr;
    logic [ADDR_W:0]   r_len, r_rd_cnt, r_words_done;
    logic [DATA_W-1:0] w_wdata;
`ifdef MEM_COPY_FILL_EN
    logic              r_fill;
    logic [DATA_W-1:0] r_fill_data;
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= S_IDLE;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_aborted    <= 1'b0;
            r_ena        <= 1'b0;
            r_enb        <= 1'b0;
            r_web        <= 1'b0;
            r_addra      <= '0;
            r_addrb      <= '0;
            r_wr_addr    <= '0;
            r_len        <= '0;
            r_rd_cnt     <= '0;
            r_words_done <= '0;
`ifdef MEM_COPY_FILL_EN
            r_fill       <= 1'b0;
            r_fill_data  <= '0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_words_done <= '0;
                        r_aborted    <= 1'b0;
                        r_len        <= bus.len;
                        r_wr_addr    <= bus.dst_base;
`ifdef MEM_COPY_FILL_EN
                        r_fill       <= bus.fill_mode;
                        r_fill_data  <= bus.fill_data;
`endif
                        if (bus.len == '0) begin
                            r_done  <= 1'b1;
                            r_state <= S_DONE;
                        end
`ifdef MEM_COPY_FILL_EN
                        else if (bus.fill_mode) begin
                            r_busy       <= 1'b1;
                            r_enb        <= 1'b1;
                            r_web        <= 1'b1;
                            r_addrb      <= bus.dst_base;
                            r_wr_addr    <= bus.dst_base + ADDR_ONE;
                            r_words_done <= CNT_ONE;
                            r_state      <= S_RUN;
                        end
`endif
                        else begin
                            r_busy   <= 1'b1;
                            r_ena    <= 1'b1;
                            r_addra  <= bus.src_base;
                            r_rd_cnt <= CNT_ONE;
                            r_state  <= S_RUN;
                        end
                    end
                end
                S_RUN: begin
`ifdef MEM_COPY_FILL_EN
                    if (r_fill) begin
                        // No read latency in fill mode, so the last write ends the transfer directly.
                        if (bus.abort || r_words_done == r_len) begin
                            r_enb     <= 1'b0;
                            r_web     <= 1'b0;
                            r_busy    <= 1'b0;
                            r_done    <= 1'b1;
                            r_aborted <= bus.abort && (r_words_done != r_len);
                            r_state   <= S_DONE;
                        end else begin
                            r_addrb      <= r_wr_addr;
                            r_wr_addr    <= r_wr_addr + ADDR_ONE;
                            r_words_done <= r_words_done + CNT_ONE;
                        end
                    end else
`endif
                    begin
                        // Every RUN cycle had a read in flight, so the next cycle writes it.
                        r_enb        <= 1'b1;
                        r_web        <= 1'b1;
                        r_addrb      <= r_wr_addr;
                        r_wr_addr    <= r_wr_addr + ADDR_ONE;
                        r_words_done <= r_words_done + CNT_ONE;
                        if (bus.abort || r_rd_cnt == r_len) begin
                            r_ena     <= 1'b0;
                            r_aborted <= bus.abort && (r_rd_cnt != r_len);
                            r_state   <= S_DRAIN;
                        end else begin
                            r_addra  <= r_addra + ADDR_ONE;
                            r_rd_cnt <= r_rd_cnt + CNT_ONE;
                        end
                    end
                end
                S_DRAIN: begin
                    r_enb   <= 1'b0;
                    r_web   <= 1'b0;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b1;
                    r_state <= S_DONE;
                end
                S_DONE: begin
                    r_done    <= 1'b0;
                    r_aborted <= 1'b0;
                    r_state   <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Write data is the RAM read port passed straight through; gating keeps it 0 when idle or in reset.
`ifdef MEM_COPY_FILL_EN
    assign w_wdata = r_fill ? r_fill_data : bus.doa;
`else
    assign w_wdata = bus.doa;
`endif

    assign bus.dib        = r_enb ? w_wdata : '0;
    assign bus.busy       = r_busy;
    assign bus.done       = r_done;
    assign bus.aborted    = r_aborted;
    assign bus.words_done = r_words_done;
    assign bus.ena        = r_ena;
    assign bus.wea        = 1'b0;
    assign bus.addra      = r_addra;
    assign bus.enb        = r_enb;
    assign bus.web        = r_web;
    assign bus.addrb      = r_addrb;
endmodule

// File: tb/tb_mem_copy_engine.sv
// tb/tb_mem_copy_engine.sv - scoreboard testbench for mem_copy_engine with a behavioural dual-port RAM
module tb_mem_copy_engine;
    localparam int AW = 6;
    localparam int DW = 16;

    typedef struct packed {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } wr_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mem_copy_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();
    mem_copy_engine #(.ADDR_W(AW), .DATA_W(DW)) dut (.i_clk(clk), .i_rst_n(rst_n), .bus(bus));

    logic [DW-1:0] mem [0:(1<<AW)-1];

    always @(posedge clk) begin
        if (bus.ena) bus.doa <= mem[bus.addra];
        if (bus.enb && bus.web) mem[bus.addrb] <= bus.dib;
    end

    int total = 0, passed = 0;
    int cyc, done_cyc, n_ena, n_enb, n_busy, n_done;
    logic done_ab;
    logic [AW:0] done_wd;
    wr_t q[$];
    logic [AW-1:0] rd_log[$];

    // One cycle of the scoreboard: sample at the falling edge and retire any port-B write.
    task automatic tick();
        wr_t e;
        @(negedge clk);
        cyc++;
        if (bus.ena === 1'b1) begin n_ena++; rd_log.push_back(bus.addra); end
        if (bus.busy === 1'b1) n_busy++;
        if (bus.done === 1'b1) begin
            n_done++;
            if (done_cyc < 0) begin done_cyc = cyc; done_ab = bus.aborted; done_wd = bus.words_done; end
        end
        if (bus.enb === 1'b1) begin
            n_enb++;
            total++;
            if (q.size() == 0) begin
                $display("FAIL sb_write unexpected: addr=%0d data=%h, required no write", bus.addrb, bus.dib);
            end else begin
                e = q.pop_front();
                if (bus.addrb !== e.a || bus.dib !== e.d || bus.web !== 1'b1 || bus.wea !== 1'b0)
                    $display("FAIL sb_write got addr=%0d data=%h web=%b wea=%b, required addr=%0d data=%h web=1 wea=0",
                             bus.addrb, bus.dib, bus.web, bus.wea, e.a, e.d);
                else passed++;
            end
        end
    endtask

    task automatic launch(input logic [AW-1:0] src, input logic [AW-1:0] dst, input logic [AW:0] n,
                          input logic fill, input logic [DW-1:0] fdata);
        logic [AW-1:0] s, d;
        bus.src_base = src;
        bus.dst_base = dst;
        bus.len      = n;
`ifdef MEM_COPY_FILL_EN
        bus.fill_mode = fill;
        bus.fill_data = fdata;
`endif
        for (int k = 0; k < int'(n); k++) begin
            s = src + AW'(k);
            d = dst + AW'(k);
            q.push_back(wr_t'{a: d, d: (fill ? fdata : mem[s])});
        end
        cyc = 0; done_cyc = -1; n_ena = 0; n_enb = 0; n_busy = 0; n_done = 0;
        done_ab = 1'bx; done_wd = 'x;
        rd_log.delete();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    task automatic run_to_done(input int limit);
        while (done_cyc < 0 && cyc < limit) tick();
        tick();
        tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if ({bus.busy, bus.done, bus.aborted, bus.ena, bus.enb, bus.web, bus.wea} !== 7'b0 ||
            bus.addra !== '0 || bus.addrb !== '0 || bus.dib !== '0 || bus.words_done !== '0)
            $display("FAIL reset_outputs got busy=%b done=%b ena=%b enb=%b addra=%0d addrb=%0d dib=%h wd=%0d, required all 0",
                     bus.busy, bus.done, bus.ena, bus.enb, bus.addra, bus.addrb, bus.dib, bus.words_done);
        else passed++;
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_copy();
        for (int i = 0; i < 8; i++) mem[i] = 16'h1000 + 16'(i);
        launch(6'd0, 6'd32, 7'd8, 1'b0, 16'h0);
        run_to_done(100);
        total++; if (done_cyc !== 10) $display("FAIL copy_done_cycle got %0d, required 10", done_cyc); else passed++;
        total++; if (done_wd !== 7'd8 || done_ab !== 1'b0) $display("FAIL copy_status got wd=%0d ab=%b, required wd=8 ab=0", done_wd, done_ab); else passed++;
        total++; if (n_ena !== 8 || n_busy !== 9) $display("FAIL copy_counts got ena=%0d busy=%0d, required ena=8 busy=9", n_ena, n_busy); else passed++;
        total++; if (bus.words_done !== 7'd8) $display("FAIL copy_wd_hold got %0d, required 8", bus.words_done); else passed++;
        for (int i = 0; i < 8; i++) begin
            total++;
            if (mem[32+i] !== 16'h1000 + 16'(i)) $display("FAIL copy_mem[%0d] got %h, required %h", 32+i, mem[32+i], 16'h1000 + 16'(i));
            else passed++;
        end
        total++; if (q.size() != 0) $display("FAIL copy_sb_left got %0d, required 0", q.size()); else passed++;
    endtask

    task automatic test_wrap();
        logic [AW-1:0] exp_rd [4];
        exp_rd = '{6'd62, 6'd63, 6'd0, 6'd1};
        mem[62] = 16'hBEE0; mem[63] = 16'hBEE1; mem[0] = 16'hBEE2; mem[1] = 16'hBEE3;
        launch(6'd62, 6'd10, 7'd4, 1'b0, 16'h0);
        run_to_done(100);
        total++; if (done_cyc !== 6) $display("FAIL wrap_done_cycle got %0d, required 6", done_cyc); else passed++;
        for (int i = 0; i < 4; i++) begin
            total++;
            if (rd_log.size() != 4 || rd_log[i] !== exp_rd[i] || mem[10+i] !== 16'hBEE0 + 16'(i))
                $display("FAIL wrap_%0d got rd=%0d mem=%h, required rd=%0d mem=%h", i,
                         (rd_log.size() > i) ? rd_log[i] : 6'h3f, mem[10+i], exp_rd[i], 16'hBEE0 + 16'(i));
            else passed++;
        end
    endtask

    task automatic test_len_zero();
        launch(6'd5, 6'd20, 7'd0, 1'b0, 16'h0);
        run_to_done(20);
        total++; if (done_cyc !== 1) $display("FAIL len0_done_cycle got %0d, required 1", done_cyc); else passed++;
        total++; if (n_ena !== 0 || n_enb !== 0 || n_busy !== 0) $display("FAIL len0_activity got ena=%0d enb=%0d busy=%0d, required 0", n_ena, n_enb, n_busy); else passed++;
        total++; if (done_ab !== 1'b0 || done_wd !== 7'd0) $display("FAIL len0_status got ab=%b wd=%0d, required 0/0", done_ab, done_wd); else passed++;
    endtask

    task automatic test_start_while_busy();
        for (int i = 0; i < 4; i++) mem[i] = 16'h2200 + 16'(i);
        launch(6'd0, 6'd20, 7'd4, 1'b0, 16'h0);
        tick();
        bus.start = 1'b1; bus.src_base = 6'd40; bus.dst_base = 6'd50; bus.len = 7'd8;
        tick();
        bus.start = 1'b0;
        run_to_done(100);
        total++; if (done_cyc !== 6 || done_wd !== 7'd4) $display("FAIL busy_start got done=%0d wd=%0d, required done=6 wd=4", done_cyc, done_wd); else passed++;
        total++; if (n_enb !== 4 || n_done !== 1) $display("FAIL busy_start_counts got enb=%0d done=%0d, required 4/1", n_enb, n_done); else passed++;
    endtask

    task automatic test_abort();
        for (int i = 0; i < 16; i++) mem[i] = 16'h3300 + 16'(i);
        launch(6'd0, 6'd40, 7'd16, 1'b0, 16'h0);
        while (cyc < 5) tick();
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        run_to_done(100);
        total++; if (n_enb !== 5 || n_ena !== 5) $display("FAIL abort_counts got enb=%0d ena=%0d, required 5/5", n_enb, n_ena); else passed++;
        total++; if (done_cyc !== 7 || done_ab !== 1'b1 || done_wd !== 7'd5)
            $display("FAIL abort_status got done=%0d ab=%b wd=%0d, required done=7 ab=1 wd=5", done_cyc, done_ab, done_wd);
        else passed++;
        total++; if (q.size() != 11) $display("FAIL abort_sb_left got %0d, required 11", q.size()); else passed++;
        q.delete();
    endtask

    task automatic test_reset_mid();
        int wr_before;
        launch(6'd0, 6'd48, 7'd16, 1'b0, 16'h0);
        while (cyc < 4) tick();
        #2 rst_n = 1'b0;
        #1;
        total++;
        if ({bus.busy, bus.done, bus.ena, bus.enb, bus.web} !== 5'b0 || bus.dib !== '0 || bus.words_done !== '0 || bus.addra !== '0)
            $display("FAIL reset_async got busy=%b ena=%b enb=%b dib=%h wd=%0d, required all 0", bus.busy, bus.ena, bus.enb, bus.dib, bus.words_done);
        else passed++;
        q.delete();
        wr_before = n_enb;
        repeat (4) tick();
        total++; if (n_done !== 0 || n_enb !== wr_before) $display("FAIL reset_quiet got done=%0d writes=%0d, required 0/%0d", n_done, n_enb, wr_before); else passed++;
        rst_n = 1'b1;
        tick();
        for (int i = 0; i < 3; i++) mem[i] = 16'h4400 + 16'(i);
        launch(6'd0, 6'd20, 7'd3, 1'b0, 16'h0);
        run_to_done(100);
        total++; if (done_cyc !== 5 || done_wd !== 7'd3 || mem[22] !== 16'h4402)
            $display("FAIL reset_recover got done=%0d wd=%0d mem22=%h, required 5/3/4402", done_cyc, done_wd, mem[22]);
        else passed++;
    endtask

`ifdef MEM_COPY_FILL_EN
    task automatic test_fill();
        launch(6'd0, 6'd60, 7'd8, 1'b1, 16'hA5A5);
        bus.fill_mode = 1'b0;
        run_to_done(100);
        total++; if (done_cyc !== 9 || n_ena !== 0 || done_wd !== 7'd8)
            $display("FAIL fill_status got done=%0d ena=%0d wd=%0d, required 9/0/8", done_cyc, n_ena, done_wd);
        else passed++;
        for (int i = 0; i < 8; i++) begin
            total++;
            if (mem[(60+i)%64] !== 16'hA5A5) $display("FAIL fill_mem[%0d] got %h, required a5a5", (60+i)%64, mem[(60+i)%64]);
            else passed++;
        end
    endtask
`endif

    initial begin
        for (int i = 0; i < (1<<AW); i++) mem[i] = 16'h0F00 + 16'(i);
        bus.start = 1'b0; bus.abort = 1'b0; bus.src_base = '0; bus.dst_base = '0; bus.len = '0; bus.doa = '0;
`ifdef MEM_COPY_FILL_EN
        bus.fill_mode = 1'b0; bus.fill_data = '0;
`endif
        test_reset();
        test_copy();
        test_wrap();
        test_len_zero();
        test_start_while_busy();
        test_abort();
        test_reset_mid();
`ifdef MEM_COPY_FILL_EN
        test_fill();
`endif
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
